// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
//   Shared constants and types for the 1-to-2 TDM demultiplexer.
//   DEFAULT_WIDTH : default data word width
//   FIFO_DEPTH    : entries per output channel buffer (fixed at 2)
//   CNT_W         : width of the per-channel accept counters
//   chan_e        : output channel selector (CH0 / CH1)
package tdm_demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int FIFO_DEPTH    = 2;
  localparam int CNT_W         = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

endpackage

// File: rtl/chan_fifo.sv
// chan_fifo
//   Small synchronous FIFO with valid/ready handshakes on both sides.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : push handshake; in_ready = not full (no bypass)
//     in_data               : word to push
//     out_valid/out_ready   : pop handshake; out_valid = not empty
//     out_data              : head entry (zero after reset)
module chan_fifo
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Readiness depends only on the registered count, so a pop in the
  // same cycle never frees space for a push into a full buffer.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is cleared on reset so out_data reads zero until a new word lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux_1to2.sv
// tdm_demux_1to2
//   Routes an upstream valid/ready word stream to one of two buffered
//   output channels, either by in_sel or by internal round-robin.
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     in_valid/in_ready/in_data   : upstream handshake and word
//     in_sel                      : destination when auto_mode = 0
//     auto_mode                   : 1 = alternate channels, ignore in_sel
//     outN_valid/outN_ready/outN_data : per-channel downstream handshake
//     cnt0, cnt1                  : words accepted per channel, modulo 256
module tdm_demux_1to2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             auto_mode,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  chan_e target;
  chan_e rr;
  logic  push0_valid;
  logic  push1_valid;
  logic  push0_ready;
  logic  push1_ready;
  logic  accept;

  // In auto mode the round-robin bit is the only source of the target;
  // a full target stalls input rather than skipping to the other channel.
  always_comb begin
    target = auto_mode ? rr : chan_e'(in_sel);
  end

  assign push0_valid = in_valid & (target == CH0);
  assign push1_valid = in_valid & (target == CH1);

  // Gated with rst_n so upstream sees no readiness while reset is held.
  assign in_ready = rst_n & ((target == CH1) ? push1_ready : push0_ready);
  assign accept   = in_valid & in_ready;

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push0_valid),
    .in_ready  (push0_ready),
    .in_data   (in_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data)
  );

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push1_valid),
    .in_ready  (push1_ready),
    .in_data   (in_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
  );

  // rr is held at CH0 outside auto mode so every auto session starts at
  // channel 0; counters wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr   <= CH0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (!auto_mode) begin
        rr <= CH0;
      end else if (accept) begin
        rr <= (rr == CH0) ? CH1 : CH0;
      end
      if (accept && (target == CH0)) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (accept && (target == CH1)) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// tb_tdm_demux_1to2
//   Self-checking bench for tdm_demux_1to2. A negedge monitor keeps a
//   reference model (per-channel expected queues, round-robin bit, counters)
//   and checks handshakes, data order and counters every cycle; the
//   scenario tasks add targeted checks of their own.
module tb_tdm_demux_1to2;
  import tdm_demux_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         auto_mode = 1'b0;
  logic         out0_valid;
  logic         out0_ready = 1'b1;
  logic [W-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready = 1'b1;
  logic [W-1:0] out1_data;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         m_rr = 1'b0;
  logic [7:0]   m_cnt0 = '0;
  logic [7:0]   m_cnt1 = '0;

  always #5 clk = ~clk;

  tdm_demux_1to2 #(.WIDTH(W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .auto_mode  (auto_mode),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // Reference model and scoreboard, evaluated between edges.
  always @(negedge clk) begin : monitor
    logic tgt;
    logic exp_rdy;
    logic acc;
    if (rst_n) begin
      tgt     = auto_mode ? m_rr : in_sel;
      exp_rdy = tgt ? (q1.size() < 2) : (q0.size() < 2);
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("[TB] FAIL mon_in_ready: got %0b expected %0b at %0t", in_ready, exp_rdy, $time);
      end
      n_checks++;
      if (out0_valid !== (q0.size() != 0)) begin
        n_fail++;
        $display("[TB] FAIL mon_out0_valid: got %0b expected %0b at %0t", out0_valid, (q0.size() != 0), $time);
      end
      n_checks++;
      if (out1_valid !== (q1.size() != 0)) begin
        n_fail++;
        $display("[TB] FAIL mon_out1_valid: got %0b expected %0b at %0t", out1_valid, (q1.size() != 0), $time);
      end
      n_checks++;
      if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
        n_fail++;
        $display("[TB] FAIL mon_counters: got %0d/%0d expected %0d/%0d at %0t", cnt0, cnt1, m_cnt0, m_cnt1, $time);
      end
      if (q0.size() != 0 && out0_ready) begin
        n_checks++;
        if (out0_data !== q0[0]) begin
          n_fail++;
          $display("[TB] FAIL mon_out0_data: got %0h expected %0h at %0t", out0_data, q0[0], $time);
        end
        void'(q0.pop_front());
      end
      if (q1.size() != 0 && out1_ready) begin
        n_checks++;
        if (out1_data !== q1[0]) begin
          n_fail++;
          $display("[TB] FAIL mon_out1_data: got %0h expected %0h at %0t", out1_data, q1[0], $time);
        end
        void'(q1.pop_front());
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        if (tgt) begin
          q1.push_back(in_data);
          m_cnt1++;
        end else begin
          q0.push_back(in_data);
          m_cnt0++;
        end
      end
      if (!auto_mode) m_rr = 1'b0;
      else if (acc) m_rr = ~m_rr;
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    m_rr = 1'b0;
    m_cnt0 = '0;
    m_cnt1 = '0;
  endtask

  // Present one word and hold it until accepted; reports cycles taken.
  task automatic send(input logic [W-1:0] d, input logic sel, output int cycles);
    bit done;
    done = 0;
    cycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    while (!done && cycles < 40) begin
      @(negedge clk);
      done = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_sel   = 1'($urandom);
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL send_timeout: word %0h got no accept in %0d cycles, expected accept", d, cycles);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d words pending, expected 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out0_valid, out1_valid, in_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_valids: got %03b expected 000", {out0_valid, out1_valid, in_ready});
    end
    n_checks++;
    if ({out0_data, out1_data} !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %04h expected 0000", {out0_data, out1_data});
    end
    n_checks++;
    if ({cnt0, cnt1} !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
    #10 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_manual();
    int c;
    auto_mode = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'h11, 1'b0, c);
    n_checks++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h11, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL manual_latency_11: got v=%0b d=%0h v1=%0b expected v=1 d=11 v1=0", out0_valid, out0_data, out1_valid);
    end
    send(8'h22, 1'b1, c);
    n_checks++;
    if ({out1_valid, out1_data} !== {1'b1, 8'h22}) begin
      n_fail++;
      $display("[TB] FAIL manual_latency_22: got v=%0b d=%0h expected v=1 d=22", out1_valid, out1_data);
    end
    send(8'h33, 1'b0, c);
    n_checks++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h33}) begin
      n_fail++;
      $display("[TB] FAIL manual_latency_33: got v=%0b d=%0h expected v=1 d=33", out0_valid, out0_data);
    end
    drain();
    n_checks++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL manual_counts: got %0d/%0d expected 2/1", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    int c;
    auto_mode = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    send(8'hB0, 1'b1, c);
    send(8'hB1, 1'b1, c);
    in_valid = 1'b1;
    in_data  = 8'hB2;
    in_sel   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_full_ready: got %0b expected 0 (cycle %0d)", in_ready, i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'hC0 + 8'(i), 1'b0, c);
      n_checks++;
      if (c !== 1) begin
        n_fail++;
        $display("[TB] FAIL bp_stream_cycles: got %0d cycles expected 1 (word %0d)", c, i);
      end
    end
    n_checks++;
    if ({out1_valid, out1_data} !== {1'b1, 8'hB0}) begin
      n_fail++;
      $display("[TB] FAIL bp_stalled_head: got v=%0b d=%0h expected v=1 d=b0", out1_valid, out1_data);
    end
    out1_ready = 1'b1;
    send(8'hB2, 1'b1, c);
    drain();
  endtask

  task automatic test_auto();
    int c;
    auto_mode = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'hA0 + 8'(i), 1'($urandom), c);
    end
    drain();
    out1_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'hD0 + 8'(i), 1'($urandom), c);
    end
    in_valid = 1'b1;
    in_data  = 8'hD5;
    for (int i = 0; i < 4; i++) begin
      in_sel = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL auto_stall_ready: got %0b expected 0 (cycle %0d)", in_ready, i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out0_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL auto_no_skip: got out0_valid=%0b expected 0", out0_valid);
    end
    out1_ready = 1'b1;
    send(8'hD5, 1'($urandom), c);
    drain();
    auto_mode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    int c;
    auto_mode = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'hE0, 1'b0, c);
    send(8'hE1, 1'b0, c);
    send(8'hE2, 1'b1, c);
    send(8'hE3, 1'b1, c);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out0_valid, out1_valid, in_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_valids: got %03b expected 000", {out0_valid, out1_valid, in_ready});
    end
    n_checks++;
    if ({out0_data, out1_data, cnt0, cnt1} !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_state: got %08h expected 00000000", {out0_data, out1_data, cnt0, cnt1});
    end
    clear_model();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'h5A, 1'b1, c);
    n_checks++;
    if ({out1_valid, out1_data, out0_valid} !== {1'b1, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL mid_first_word: got v1=%0b d1=%0h v0=%0b expected v1=1 d1=5a v0=0", out1_valid, out1_data, out0_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mid_no_stale: got %02b expected 00", {out0_valid, out1_valid});
    end
    drain();
  endtask

  task automatic test_counter_wrap();
    int c;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    auto_mode = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(8'(i), 1'b0, c);
    end
    drain();
    n_checks++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL wrap_counts: got %0d/%0d expected 1/0", cnt0, cnt1);
    end
  endtask

  initial begin
    $display("[TB] starting tdm_demux_1to2 bench");
    test_reset();
    test_manual();
    test_backpressure();
    test_auto();
    test_reset_midstream();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to2.md
TDM_DEMUX_1TO2 -- requirements
Module: tdm_demux_1to2

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Parameter: DEPTH, default 2, entries per output channel buffer; fixed at 2 for this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_sel  input  1  destination channel (0 = out0, 1 = out1); used only when auto_mode = 0.
REQ-009 auto_mode  input  1  1 = alternate destinations round-robin and ignore in_sel.
REQ-010 out0_valid / out1_valid  output  1 each  channel word present.
REQ-011 out0_ready / out1_ready  input  1 each  downstream accepts the channel word.
REQ-012 out0_data / out1_data  output  WIDTH each  channel word.
REQ-013 cnt0 / cnt1  output  8 each  words accepted into channel 0 / channel 1; modulo 256.

Function
REQ-014 Target channel: in_sel when auto_mode = 0; internal rr bit when auto_mode = 1.
REQ-015 in_ready SHALL equal NOT full(target buffer); it is combinational from the target and the registered full flags.
REQ-016 A pop in the same cycle SHALL NOT make a full buffer ready (no bypass).
REQ-017 Accept occurs when in_valid & in_ready; the word is pushed into the target buffer at that edge.
REQ-018 Latency: an accepted word SHALL appear on outN_data with outN_valid = 1 in the next cycle if that buffer was empty.
REQ-019 Each channel buffer is FIFO: outN_valid = NOT empty; outN_data = head entry; pop on outN_valid & outN_ready.
REQ-020 Simultaneous push and pop on a channel with 1 entry SHALL leave occupancy at 1 and preserve order.
REQ-021 Words to one channel SHALL never be reordered, dropped or duplicated.
REQ-022 A stalled channel SHALL NOT block the other channel when auto_mode = 0.
REQ-023 rr SHALL toggle on every accept while auto_mode = 1.
REQ-024 rr SHALL be forced to 0 while auto_mode = 0, so each auto session starts at channel 0.
REQ-025 In auto_mode, a full target SHALL hold in_ready = 0; the other channel is never skipped to.
REQ-026 cntN SHALL increment by 1 on each accept into channel N and wrap from 255 to 0.
REQ-027 in_data and in_sel SHALL be ignored when in_valid = 0; outN_data is don't-care when outN_valid = 0.

Reset
REQ-028 Asserting rst_n low SHALL immediately force:
- out0_valid = out1_valid = 0
- out0_data = out1_data = 0
- both buffers empty
- cnt0 = cnt1 = 0
- rr = 0
REQ-029 in_ready SHALL be 0 while rst_n = 0.
REQ-030 Reset mid-operation SHALL discard all buffered words.
REQ-031 After reset release, the block SHALL be ready on the first rising edge.

Structure
REQ-032 Package tdm_demux_pkg SHALL hold:
- WIDTH default
- DEPTH constant
- channel enum CH0/CH1
- counter width (8)
REQ-033 One sub-module, chan_fifo (DEPTH-entry FIFO with valid/ready on both sides), SHALL be instantiated twice.
REQ-034 Routing, rr and counters SHALL reside in the top level.

Verification
REQ-035 Manual routing: auto_mode = 0; send 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0), both readys high -> out0 gets 0x11, 0x33; out1 gets 0x22; each appears 1 cycle after accept; cnt0 = 2, cnt1 = 1.
REQ-036 Backpressure isolation: out1_ready = 0; send three words to ch1 -> in_ready drops after 2 accepts while in_valid is held. Then send sel 0 words -> accepted, and out0 streams at one word per cycle.
REQ-037 Auto mode: auto_mode = 1; send 0xA0..0xA5 -> out0 gets A0, A2, A4; out1 gets A1, A3, A5. Holding out1_ready = 0 stalls input after ch1 fills and ch0 is never skipped to.
REQ-038 Counter wrap: send 257 words to ch0 -> cnt0 = 1, cnt1 = 0, no word lost.
REQ-039 Reset mid-stream: fill both buffers, pulse rst_n low between edges -> valids, data and counters are 0 immediately. After release, the first new word emerges alone with no stale data.
